ysyx_24100029_axi_arbiter: RTL

YSYX_24100029_AXI_ARBITER -- requirements
Module: ysyx_24100029_axi_arbiter

---
 rtl/ysyx_24100029_axi_pkg.sv | 33 +++
 rtl/ysyx_24100029_arb_pick.sv | 42 ++++
 rtl/ysyx_24100029_axi_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100029_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100029_axi_pkg
// Shared types and constants for the IFU/LSU -> single AXI4 master arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, IFU_RD, LSU_RD, LSU_WR)
//   BURST_*       : AXI burst type codes
//   RESP_*        : AXI response codes
//   SIZE_4B       : AXI size code for 4-byte beats
//   is_read_grant : true for the two read grant states
// ---------------------------------------------------------------------------
package ysyx_24100029_axi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'b010;

    function automatic logic is_read_grant(input arb_state_e s);
        return (s == IFU_RD) || (s == LSU_RD);
    endfunction

endpackage

// File: rtl/ysyx_24100029_arb_pick.sv
// ---------------------------------------------------------------------------
// ysyx_24100029_arb_pick
// Combinational request-to-grant selection used by the arbiter in IDLE.
//   ifu_rd_req_i : IFU read request (ifu_arvalid)
//   lsu_rd_req_i : LSU read request (lsu_arvalid)
//   lsu_wr_req_i : LSU write request (lsu_awvalid)
//   last_lsu_i   : last read grant went to the LSU (round-robin build only)
//   grant_o      : state to enter on the next edge (IDLE when nothing pending)
// Configuration macro: YSYX_24100029_ARB_RR_EN selects round-robin between
// the two readers; writes always win.
// ---------------------------------------------------------------------------
module ysyx_24100029_arb_pick
    import ysyx_24100029_axi_pkg::*;
(
    input  logic       ifu_rd_req_i,
    input  logic       lsu_rd_req_i,
    input  logic       lsu_wr_req_i,
`ifdef YSYX_24100029_ARB_RR_EN
    input  logic       last_lsu_i,
`endif
    output arb_state_e grant_o
);

    always_comb begin
        grant_o = IDLE;
        if (lsu_wr_req_i) begin
            grant_o = LSU_WR;
        end
`ifdef YSYX_24100029_ARB_RR_EN
        // Read tie: the reader that did not get the previous read grant wins.
        else if (lsu_rd_req_i && ifu_rd_req_i) begin
            grant_o = last_lsu_i ? IFU_RD : LSU_RD;
        end
`endif
        else if (lsu_rd_req_i) begin
            grant_o = LSU_RD;
        end else if (ifu_rd_req_i) begin
            grant_o = IFU_RD;
        end
    end

endmodule

// File: rtl/ysyx_24100029_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24100029_axi_arbiter
// Shares one AXI4 master port between the IFU (read only) and the LSU
// (read + write). One transaction is granted at a time; the grant is held
// until the final R beat (reads) or the B handshake (writes), followed by a
// single IDLE cycle in which the next request is arbitrated.
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*        : IFU read channels
//   lsu_ar*/lsu_r*        : LSU read channels
//   lsu_aw*/lsu_w*/lsu_b* : LSU write channels
//   m_*                   : downstream AXI4 master port
// Configuration macro: YSYX_24100029_ARB_RR_EN (round-robin read arbitration,
// adds a last-grant register).
// ---------------------------------------------------------------------------
module ysyx_24100029_axi_arbiter
    import ysyx_24100029_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // IFU read
    input  logic                ifu_arvalid_i,
    output logic                ifu_arready_o,
    input  logic [ADDR_W-1:0]   ifu_araddr_i,
    input  logic [ID_W-1:0]     ifu_arid_i,
    input  logic [7:0]          ifu_arlen_i,
    input  logic [2:0]          ifu_arsize_i,
    input  logic [1:0]          ifu_arburst_i,
    input  logic                ifu_rready_i,
    output logic                ifu_rvalid_o,
    output logic [1:0]          ifu_rresp_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic                ifu_rlast_o,
    output logic [ID_W-1:0]     ifu_rid_o,
    // LSU read
    input  logic                lsu_arvalid_i,
    output logic                lsu_arready_o,
    input  logic [ADDR_W-1:0]   lsu_araddr_i,
    input  logic [ID_W-1:0]     lsu_arid_i,
    input  logic [7:0]          lsu_arlen_i,
    input  logic [2:0]          lsu_arsize_i,
    input  logic [1:0]          lsu_arburst_i,
    input  logic                lsu_rready_i,
    output logic                lsu_rvalid_o,
    output logic [1:0]          lsu_rresp_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_rlast_o,
    output logic [ID_W-1:0]     lsu_rid_o,
    // LSU write
    input  logic                lsu_awvalid_i,
    output logic                lsu_awready_o,
    input  logic [ADDR_W-1:0]   lsu_awaddr_i,
    input  logic [ID_W-1:0]     lsu_awid_i,
    input  logic [7:0]          lsu_awlen_i,
    input  logic [2:0]          lsu_awsize_i,
    input  logic [1:0]          lsu_awburst_i,
    input  logic                lsu_wvalid_i,
    output logic                lsu_wready_o,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    input  logic                lsu_wlast_i,
    input  logic                lsu_bready_i,
    output logic                lsu_bvalid_o,
    output logic [1:0]          lsu_bresp_o,
    output logic [ID_W-1:0]     lsu_bid_o,
    // Downstream master
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    output logic [ADDR_W-1:0]   m_araddr_o,
    output logic [ID_W-1:0]     m_arid_o,
    output logic [7:0]          m_arlen_o,
    output logic [2:0]          m_arsize_o,
    output logic [1:0]          m_arburst_o,
    output logic                m_rready_o,
    input  logic                m_rvalid_i,
    input  logic [1:0]          m_rresp_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_rlast_i,
    input  logic [ID_W-1:0]     m_rid_i,
    output logic                m_awvalid_o,
    input  logic                m_awready_i,
    output logic [ADDR_W-1:0]   m_awaddr_o,
    output logic [ID_W-1:0]     m_awid_o,
    output logic [7:0]          m_awlen_o,
    output logic [2:0]          m_awsize_o,
    output logic [1:0]          m_awburst_o,
    output logic                m_wvalid_o,
    input  logic                m_wready_i,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    output logic                m_wlast_o,
    output logic                m_bready_o,
    input  logic                m_bvalid_i,
    input  logic [1:0]          m_bresp_i,
    input  logic [ID_W-1:0]     m_bid_i
);

    arb_state_e state_q;
    arb_state_e pick_grant;
    // Set once the AR/AW of the current grant has handshaken, so a master
    // cannot slip a second address through under the same grant.
    logic       addr_done_q;
`ifdef YSYX_24100029_ARB_RR_EN
    logic       last_lsu_q;
`endif

    logic gnt_ifu, gnt_lsu_rd, gnt_lsu_wr, gnt_rd, addr_open;
    logic ar_hs, aw_hs, r_done, b_done;

    ysyx_24100029_arb_pick u_pick (
        .ifu_rd_req_i (ifu_arvalid_i),
        .lsu_rd_req_i (lsu_arvalid_i),
        .lsu_wr_req_i (lsu_awvalid_i),
`ifdef YSYX_24100029_ARB_RR_EN
        .last_lsu_i   (last_lsu_q),
`endif
        .grant_o      (pick_grant)
    );

    assign gnt_ifu    = (state_q == IFU_RD);
    assign gnt_lsu_rd = (state_q == LSU_RD);
    assign gnt_lsu_wr = (state_q == LSU_WR);
    assign gnt_rd     = is_read_grant(state_q);
    assign addr_open  = ~addr_done_q;

    // Read address: muxed by grant; valid/ready gated so IDLE shows nothing.
    assign m_arvalid_o = addr_open & ((gnt_ifu & ifu_arvalid_i) | (gnt_lsu_rd & lsu_arvalid_i));
    assign m_araddr_o  = gnt_lsu_rd ? lsu_araddr_i  : ifu_araddr_i;
    assign m_arid_o    = gnt_lsu_rd ? lsu_arid_i    : ifu_arid_i;
    assign m_arlen_o   = gnt_lsu_rd ? lsu_arlen_i   : ifu_arlen_i;
    assign m_arsize_o  = gnt_lsu_rd ? lsu_arsize_i  : ifu_arsize_i;
    assign m_arburst_o = gnt_lsu_rd ? lsu_arburst_i : ifu_arburst_i;
    assign ifu_arready_o = gnt_ifu    & addr_open & m_arready_i;
    assign lsu_arready_o = gnt_lsu_rd & addr_open & m_arready_i;

    // Read data: routed purely by grant state; payload passes through as-is.
    assign m_rready_o   = (gnt_ifu & ifu_rready_i) | (gnt_lsu_rd & lsu_rready_i);
    assign ifu_rvalid_o = gnt_ifu & m_rvalid_i;
    assign lsu_rvalid_o = gnt_lsu_rd & m_rvalid_i;
    assign ifu_rresp_o  = m_rresp_i;
    assign ifu_rdata_o  = m_rdata_i;
    assign ifu_rlast_o  = m_rlast_i;
    assign ifu_rid_o    = m_rid_i;
    assign lsu_rresp_o  = m_rresp_i;
    assign lsu_rdata_o  = m_rdata_i;
    assign lsu_rlast_o  = m_rlast_i;
    assign lsu_rid_o    = m_rid_i;

    // Write channels: only the LSU writes, so only valid/ready need gating.
    assign m_awvalid_o   = gnt_lsu_wr & addr_open & lsu_awvalid_i;
    assign lsu_awready_o = gnt_lsu_wr & addr_open & m_awready_i;
    assign m_awaddr_o    = lsu_awaddr_i;
    assign m_awid_o      = lsu_awid_i;
    assign m_awlen_o     = lsu_awlen_i;
    assign m_awsize_o    = lsu_awsize_i;
    assign m_awburst_o   = lsu_awburst_i;
    assign m_wvalid_o    = gnt_lsu_wr & lsu_wvalid_i;
    assign lsu_wready_o  = gnt_lsu_wr & m_wready_i;
    assign m_wdata_o     = lsu_wdata_i;
    assign m_wstrb_o     = lsu_wstrb_i;
    assign m_wlast_o     = lsu_wlast_i;
    assign m_bready_o    = gnt_lsu_wr & lsu_bready_i;
    assign lsu_bvalid_o  = gnt_lsu_wr & m_bvalid_i;
    assign lsu_bresp_o   = m_bresp_i;
    assign lsu_bid_o     = m_bid_i;

    assign ar_hs  = m_arvalid_o & m_arready_i;
    assign aw_hs  = m_awvalid_o & m_awready_i;
    assign r_done = gnt_rd & m_rvalid_i & m_rready_o & m_rlast_i;
    assign b_done = m_bvalid_i & m_bready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_done_q <= 1'b0;
`ifdef YSYX_24100029_ARB_RR_EN
            last_lsu_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= pick_grant;
                    addr_done_q <= 1'b0;
`ifdef YSYX_24100029_ARB_RR_EN
                    // Only read grants take part in the rotation.
                    if (pick_grant == IFU_RD) begin
                        last_lsu_q <= 1'b0;
                    end else if (pick_grant == LSU_RD) begin
                        last_lsu_q <= 1'b1;
                    end
`endif
                end
                IFU_RD, LSU_RD: begin
                    if (ar_hs) begin
                        addr_done_q <= 1'b1;
                    end
                    if (r_done) begin
                        state_q <= IDLE;
                    end
                end
                LSU_WR: begin
                    if (aw_hs) begin
                        addr_done_q <= 1'b1;
                    end
                    if (b_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
